// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC
// and the fetch unit state encoding.
package cpu_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 8;
   localparam int CNT_W   = 16;

   localparam logic [PC_W-1:0] RESET_PC = 8'h00;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit.
// Holds pc, fetches from imem, hands instr to decode.
module pc_fetch_unit
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    next_pc,
   input  logic               advance,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [PC_W-1:0]    curr_pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [CNT_W-1:0]   fetch_count
);

   fetch_state_t       state, state_n;
   logic [PC_W-1:0]    pc, pc_n;
   logic [PC_W-1:0]    pend, pend_n;
   logic [INSTR_W-1:0] instr_n;
   logic               valid_n;
   logic [CNT_W-1:0]   cnt_n;
   logic               req_n;
   logic               ack;

   // an ack only counts while a request is actually out
   assign ack       = imem_ack & imem_req;
   assign imem_addr = pc;
   assign curr_pc   = pc;

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pend        <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         fetch_count <= '0;
         imem_req    <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         pend        <= pend_n;
         instr       <= instr_n;
         instr_valid <= valid_n;
         fetch_count <= cnt_n;
         imem_req    <= req_n;
      end
   end

   // next-state, pc selection and handshake decisions
   always_comb begin
      state_n = state;
      pc_n    = pc;
      pend_n  = pend;
      instr_n = instr;
      valid_n = instr_valid;
      cnt_n   = fetch_count;
      unique case (state)
         FETCH: begin
            if (redirect) begin
               if (ack) begin
                  pc_n = redirect_pc;
               end else begin
                  pend_n  = redirect_pc;
                  state_n = DRAIN;
               end
            end else if (ack) begin
               instr_n = imem_data;
               valid_n = 1'b1;
               state_n = READY;
            end
         end
         READY: begin
            if (redirect) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
               state_n = FETCH;
            end else if (advance && !stall) begin
               pc_n    = next_pc;
               valid_n = 1'b0;
               state_n = FETCH;
               if (fetch_count != '1)
                  cnt_n = fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DRAIN: begin
            valid_n = 1'b0;
            if (ack) begin
               pc_n    = redirect ? redirect_pc : pend;
               state_n = FETCH;
            end else if (redirect) begin
               pend_n = redirect_pc;
            end
         end
         default: begin
            state_n = FETCH;
            valid_n = 1'b0;
         end
      endcase
      req_n = (state_n != READY);
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and random checks of pc_fetch_unit against
// a behavioural model of the fetch/redirect rules.
module tb_pc_fetch_unit;
   import cpu_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [PC_W-1:0]    next_pc;
   logic               advance;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [PC_W-1:0]    curr_pc;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [CNT_W-1:0]   fetch_count;

   int total = 0;
   int bad   = 0;

   // reference model: valid instr held, or fetching;
   // a non-negative drain target means a redirect is
   // waiting for the old request to come back
   logic [7:0] m_pc    = 8'h00;
   logic [7:0] m_instr = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_req   = 1'b0;
   int         m_cnt   = 0;
   int         m_drain = -1;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk(clk),
      .reset(reset),
      .next_pc(next_pc),
      .advance(advance),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_data(imem_data),
      .curr_pc(curr_pc),
      .instr(instr),
      .instr_valid(instr_valid),
      .fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model();
      logic got;
      if (reset) begin
         m_pc = RESET_PC; m_instr = 8'h00; m_valid = 1'b0;
         m_cnt = 0; m_drain = -1; m_req = 1'b0;
         return;
      end
      got = imem_ack && m_req;
      if (m_valid) begin
         if (redirect) begin
            m_pc = redirect_pc; m_valid = 1'b0;
         end else if (advance && !stall) begin
            m_pc = next_pc; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
         end
      end else if (m_drain >= 0) begin
         if (got) begin
            m_pc = redirect ? redirect_pc : 8'(m_drain);
            m_drain = -1;
         end else if (redirect) begin
            m_drain = int'(redirect_pc);
         end
      end else begin
         if (redirect) begin
            if (got) m_pc = redirect_pc;
            else     m_drain = int'(redirect_pc);
         end else if (got) begin
            m_instr = imem_data; m_valid = 1'b1;
         end
      end
      m_req = !m_valid;
   endtask

   task automatic cyc();
      @(posedge clk);
      model();
      #1;
      chk("req", 32'(imem_req), 32'(m_req));
      chk("curr_pc", 32'(curr_pc), 32'(m_pc));
      if (m_req) chk("addr", 32'(imem_addr), 32'(m_pc));
      chk("valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", 32'(instr), 32'(m_instr));
      chk("count", 32'(fetch_count), 32'(m_cnt));
   endtask

   initial begin
      reset = 1'b1; next_pc = '0; advance = 1'b0; stall = 1'b0;
      redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
      imem_data = '0;
      cyc(); cyc();
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);

      // reset then ack two cycles after req
      reset = 1'b0;
      cyc();
      chk("t1_req", 32'(imem_req), 32'h1);
      chk("t1_addr", 32'(imem_addr), 32'h00);
      cyc();
      imem_ack = 1'b1; imem_data = 8'hA5;
      cyc();
      imem_ack = 1'b0;
      chk("t1_instr", 32'(instr), 32'hA5);
      chk("t1_valid", 32'(instr_valid), 32'h1);
      chk("t1_pc", 32'(curr_pc), 32'h00);

      // accepted advance
      next_pc = 8'h07; advance = 1'b1;
      cyc();
      advance = 1'b0;
      chk("t2_req", 32'(imem_req), 32'h1);
      chk("t2_addr", 32'(imem_addr), 32'h07);
      chk("t2_cnt", 32'(fetch_count), 32'h1);
      imem_ack = 1'b1; imem_data = 8'h11;
      cyc();
      imem_ack = 1'b0;

      // advance held off by stall
      next_pc = 8'h10; advance = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t3_hold", 32'(curr_pc), 32'h07);
      end
      stall = 1'b0;
      cyc();
      advance = 1'b0;
      chk("t3_load", 32'(curr_pc), 32'h10);

      // redirect before ack drains the old request
      redirect = 1'b1; redirect_pc = 8'h40;
      cyc();
      redirect = 1'b0;
      chk("t4_drain_addr", 32'(imem_addr), 32'h10);
      imem_ack = 1'b1; imem_data = 8'hFF;
      cyc();
      imem_ack = 1'b0;
      chk("t4_valid", 32'(instr_valid), 32'h0);
      chk("t4_addr", 32'(imem_addr), 32'h40);
      cyc();
      chk("t4_wait", 32'(instr_valid), 32'h0);
      imem_ack = 1'b1; imem_data = 8'h3C;
      cyc();
      imem_ack = 1'b0;
      chk("t4_instr", 32'(instr), 32'h3C);

      // ack and redirect in the same cycle
      next_pc = 8'h30; advance = 1'b1;
      cyc();
      advance = 1'b0;
      imem_ack = 1'b1; imem_data = 8'h77;
      redirect = 1'b1; redirect_pc = 8'h20;
      cyc();
      imem_ack = 1'b0; redirect = 1'b0;
      chk("t5_req", 32'(imem_req), 32'h1);
      chk("t5_addr", 32'(imem_addr), 32'h20);
      chk("t5_valid", 32'(instr_valid), 32'h0);

      // reset in drain with a simultaneous ack
      redirect = 1'b1; redirect_pc = 8'h55;
      cyc();
      redirect = 1'b0;
      reset = 1'b1; imem_ack = 1'b1; imem_data = 8'h99;
      cyc();
      reset = 1'b0; imem_ack = 1'b0;
      chk("t6_req", 32'(imem_req), 32'h0);
      chk("t6_cnt", 32'(fetch_count), 32'h0);
      chk("t6_pc", 32'(curr_pc), 32'(RESET_PC));
      cyc();
      chk("t6_addr", 32'(imem_addr), 32'(RESET_PC));

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 99) < 2);
         advance     = ($urandom_range(0, 99) < 60);
         stall       = ($urandom_range(0, 99) < 30);
         redirect    = ($urandom_range(0, 99) < 10);
         imem_ack    = ($urandom_range(0, 99) < 40);
         next_pc     = 8'($urandom);
         redirect_pc = 8'($urandom);
         imem_data   = 8'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
